// File: rtl/dcache_pkg.sv
// Shared types and geometry helpers for the write-through data cache.
package dcache_pkg;

  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    RD_MISS,
    WR_THRU
  } state_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  // Word-addressed: the two byte-offset bits never reach the tag.
  function automatic int tag_w(input int lines);
    return ADDR_W - 2 - $clog2(lines);
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Valid bits, tag and data storage for a direct-mapped cache of one-word lines.
// Single write port, combinational lookup.
module dcache_array
  import dcache_pkg::*;
#(
  parameter  int LINES = 16,
  localparam int IDX   = idx_w(LINES),
  localparam int TAG   = tag_w(LINES)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_clr,
  input  logic            i_we,
  input  logic            i_set_valid,
  input  logic [IDX-1:0]  i_idx,
  input  logic [TAG-1:0]  i_tag,
  input  logic [31:0]     i_wdata,
  output logic            o_hit,
  output logic [31:0]     o_rdata
);

  logic [LINES-1:0] r_valid;
  logic [TAG-1:0]   r_tag  [LINES];
  logic [31:0]      r_data [LINES];

  // The fill's own valid bit is applied after the global clear so it survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else begin
      if (i_clr) r_valid <= '0;
      if (i_we && i_set_valid) r_valid[i_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_idx]  <= i_tag;
      r_data[i_idx] <= i_wdata;
    end
  end

  assign o_hit   = r_valid[i_idx] && (r_tag[i_idx] == i_tag);
  assign o_rdata = r_data[i_idx];

endmodule

// File: rtl/dcache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache: FSM, hit/miss
// counters and the handshaked memory-port drivers.
module dcache_wt
  import dcache_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpuReq,
  input  logic              cpuWe,
  input  logic [ADDR_W-1:0] cpuAdr,
  input  logic [31:0]       cpuWdata,
  output logic [31:0]       cpuRdata,
  output logic              cpuStall,
  input  logic              inv,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAdr,
  output logic [31:0]       memWdata,
  input  logic [31:0]       memRdata,
  input  logic              memAck,
  output logic [15:0]       hitCnt,
  output logic [15:0]       missCnt
);

  localparam int IDX = idx_w(LINES);
  localparam int TAG = tag_w(LINES);

  state_t         r_state, w_state_next;
  logic [15:0]    r_hit_cnt, r_miss_cnt;
  logic [IDX-1:0] w_idx;
  logic [TAG-1:0] w_tag;
  logic           w_hit, w_arr_we, w_fill, w_hit_inc, w_miss_inc;
  logic [31:0]    w_line_data;
  logic           w_unused;

  assign w_idx    = cpuAdr[IDX+1:2];
  assign w_tag    = cpuAdr[ADDR_W-1:IDX+2];
  assign w_unused = ^cpuAdr[1:0];

  dcache_array #(.LINES(LINES)) u_array (
    .clk         (clk),
    .rst         (rst),
    .i_clr       (inv),
    .i_we        (w_arr_we),
    .i_set_valid (w_fill),
    .i_idx       (w_idx),
    .i_tag       (w_tag),
    .i_wdata     (w_fill ? memRdata : cpuWdata),
    .o_hit       (w_hit),
    .o_rdata     (w_line_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hit_inc)  r_hit_cnt  <= r_hit_cnt + 16'd1;
      if (w_miss_inc) r_miss_cnt <= r_miss_cnt + 16'd1;
    end
  end

  always_comb begin
    w_state_next = r_state;
    cpuRdata     = '0;
    cpuStall     = 1'b0;
    w_arr_we     = 1'b0;
    w_fill       = 1'b0;
    w_hit_inc    = 1'b0;
    w_miss_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (cpuReq) begin
          if (cpuWe) begin
            cpuStall     = 1'b1;
            w_state_next = WR_THRU;
          end else if (w_hit) begin
            cpuRdata  = w_line_data;
            w_hit_inc = 1'b1;
          end else begin
            cpuStall     = 1'b1;
            w_miss_inc   = 1'b1;
            w_state_next = RD_MISS;
          end
        end
      end
      RD_MISS: begin
        if (memAck) begin
          cpuRdata     = memRdata;
          w_arr_we     = 1'b1;
          w_fill       = 1'b1;
          w_state_next = IDLE;
        end else begin
          cpuStall = 1'b1;
        end
      end
      WR_THRU: begin
        // Stores update the line only when it is already resident.
        if (memAck) begin
          w_arr_we     = w_hit;
          w_state_next = IDLE;
        end else begin
          cpuStall = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign memReq   = (r_state != IDLE);
  assign memWe    = (r_state == WR_THRU);
  assign memAdr   = memReq ? {cpuAdr[ADDR_W-1:2], 2'b00} : '0;
  assign memWdata = memWe ? cpuWdata : '0;
  assign hitCnt   = r_hit_cnt;
  assign missCnt  = r_miss_cnt;

endmodule

// File: tb/tb_dcache_wt.sv
// Scoreboard bench for dcache_wt: directed scenarios then random traffic,
// checked against an array-based cache/memory reference model.
module tb_dcache_wt;

  localparam int LINES = 16;
  localparam int IDX   = 4;

  logic        clk, rst;
  logic        cpuReq, cpuWe, inv;
  logic [31:0] cpuAdr, cpuWdata, cpuRdata;
  logic        cpuStall;
  logic        memReq, memWe, memAck;
  logic [31:0] memAdr, memWdata, memRdata;
  logic [15:0] hitCnt, missCnt;

  dcache_wt #(.LINES(LINES)) dut (
    .clk      (clk),
    .rst      (rst),
    .cpuReq   (cpuReq),
    .cpuWe    (cpuWe),
    .cpuAdr   (cpuAdr),
    .cpuWdata (cpuWdata),
    .cpuRdata (cpuRdata),
    .cpuStall (cpuStall),
    .inv      (inv),
    .memReq   (memReq),
    .memWe    (memWe),
    .memAdr   (memAdr),
    .memWdata (memWdata),
    .memRdata (memRdata),
    .memAck   (memAck),
    .hitCnt   (hitCnt),
    .missCnt  (missCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          cycles;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;

  // Reference model: cache contents, memory image and load counters.
  bit          ref_valid [LINES];
  logic [31:0] ref_tag   [LINES];
  logic [31:0] ref_data  [LINES];
  logic [31:0] ref_mem   [logic [29:0]];
  logic [31:0] mem       [logic [29:0]];
  int          ref_hits = 0;
  int          ref_misses = 0;
  int          mem_lat = 0;

  function automatic logic [31:0] init_val(input logic [29:0] w);
    return ({2'b00, w} * 32'h9E3779B1) ^ 32'hA5A50F0F;
  endfunction

  function void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h, expected %h", name, act, req);
  endfunction

  function void ref_clear();
    for (int i = 0; i < LINES; i++) ref_valid[i] = 1'b0;
  endfunction

  // Memory responder: acks after mem_lat wait cycles counted from the first memReq cycle.
  initial begin
    int k;
    logic [29:0] w;
    k = 0;
    memAck = 1'b0;
    memRdata = '0;
    forever begin
      @(posedge clk);
      #1;
      memAck = 1'b0;
      memRdata = '0;
      if (memReq) begin
        if (k == mem_lat) begin
          memAck = 1'b1;
          w = memAdr[31:2];
          if (memWe) mem[w] = memWdata;
          else memRdata = mem.exists(w) ? mem[w] : init_val(w);
          k = 0;
        end else begin
          k++;
        end
      end else begin
        k = 0;
      end
    end
  end

  // Monitor: pops an expectation whenever an access completes (cpuReq and no stall).
  initial begin
    int cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc = 0;
      end else if (!cpuReq) begin
        cyc = 0;
        check("idle_rdata", cpuRdata, 32'h0);
        check("idle_memReq", 32'(memReq), 32'h0);
      end else begin
        cyc++;
        if (memReq && exp_q.size() > 0) begin
          check("memAdr", memAdr, exp_q[0].adr);
          check("memWe", 32'(memWe), 32'(exp_q[0].we));
          if (exp_q[0].we) check("memWdata", memWdata, exp_q[0].wdata);
        end
        if (!cpuStall) begin
          if (exp_q.size() == 0) begin
            check("unexpected_completion", 32'(exp_q.size()), 32'h1);
          end else begin
            e = exp_q.pop_front();
            check(e.we ? "store_rdata" : "load_rdata", cpuRdata, e.rdata);
            check("access_cycles", 32'(cyc), 32'(e.cycles));
          end
          cyc = 0;
        end
      end
    end
  end

  // One CPU access; expectations come from the reference model before the access starts.
  task automatic do_access(input bit we, input logic [31:0] adr, input logic [31:0] wd,
                           input int lat, input bit with_inv);
    logic [29:0] w;
    int          idx;
    logic [31:0] tag;
    bit          hit, done;
    exp_t        e;
    w   = adr[31:2];
    idx = int'(w % LINES);
    tag = {2'b00, w} >> IDX;
    hit = ref_valid[idx] && (ref_tag[idx] == tag);
    e.we     = we;
    e.adr    = {adr[31:2], 2'b00};
    e.wdata  = we ? wd : 32'h0;
    e.cycles = (!we && hit) ? 1 : 2 + lat;
    if (we) begin
      e.rdata = 32'h0;
      ref_mem[w] = wd;
    end else begin
      e.rdata = hit ? ref_data[idx] : (ref_mem.exists(w) ? ref_mem[w] : init_val(w));
      if (hit) ref_hits++;
      else ref_misses++;
    end
    if (with_inv) ref_clear();
    if (!we && !hit) begin
      ref_valid[idx] = 1'b1;
      ref_tag[idx]   = tag;
      ref_data[idx]  = e.rdata;
    end else if (we && ref_valid[idx] && ref_tag[idx] == tag) begin
      ref_data[idx] = wd;
    end
    exp_q.push_back(e);
    mem_lat  = lat;
    cpuReq   = 1'b1;
    cpuWe    = we;
    cpuAdr   = adr;
    cpuWdata = wd;
    inv      = with_inv;
    done     = 1'b0;
    for (int c = 0; c < lat + 10 && !done; c++) begin
      @(negedge clk);
      if (!cpuStall) done = 1'b1;
      @(posedge clk);
      #1;
      inv = 1'b0;
    end
    cpuReq = 1'b0;
    cpuWe  = 1'b0;
    check("access_done", 32'(done), 32'h1);
    check("hitCnt", 32'(hitCnt), 32'(ref_hits & 16'hFFFF));
    check("missCnt", 32'(missCnt), 32'(ref_misses & 16'hFFFF));
  endtask

  task automatic idle(input int n, input bit with_inv);
    for (int i = 0; i < n; i++) begin
      inv = with_inv && (i == 0);
      if (inv) ref_clear();
      @(posedge clk);
      #1;
    end
    inv = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; cpuReq = 1'b0; cpuWe = 1'b0; inv = 1'b0;
    cpuAdr = '0; cpuWdata = '0;
    ref_clear();
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_memReq", 32'(memReq), 32'h0);
    check("rst_memWe", 32'(memWe), 32'h0);
    check("rst_cpuStall", 32'(cpuStall), 32'h0);
    check("rst_hitCnt", 32'(hitCnt), 32'h0);
    check("rst_missCnt", 32'(missCnt), 32'h0);

    // Directed scenarios.
    mem[30'h40] = 32'hDEADBEEF;
    ref_mem[30'h40] = 32'hDEADBEEF;
    do_access(1'b0, 32'h100, 32'h0, 3, 1'b0);          // miss, 4 stall cycles
    do_access(1'b0, 32'h100, 32'h0, 0, 1'b0);          // hit
    do_access(1'b1, 32'h100, 32'h12345678, 1, 1'b0);   // store hit
    do_access(1'b0, 32'h100, 32'h0, 0, 1'b0);
    do_access(1'b1, 32'h200, 32'hCAFEF00D, 0, 1'b0);   // store miss, zero-wait
    do_access(1'b0, 32'h200, 32'h0, 0, 1'b0);          // must miss: no allocate
    do_access(1'b0, 32'h140, 32'h0, 2, 1'b0);          // conflict on index 0
    do_access(1'b0, 32'h100, 32'h0, 1, 1'b0);
    idle(2, 1'b1);
    do_access(1'b0, 32'h100, 32'h0, 0, 1'b0);          // miss after invalidate
    do_access(1'b0, 32'h100, 32'h0, 0, 1'b1);          // hit, inv same cycle
    do_access(1'b0, 32'h100, 32'h0, 0, 1'b0);

    // Reset during RD_MISS.
    mem_lat  = 50;
    cpuReq   = 1'b1;
    cpuWe    = 1'b0;
    cpuAdr   = 32'h300;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    check("miss_memReq", 32'(memReq), 32'h1);
    rst = 1'b1;
    cpuReq = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ref_clear();
    ref_hits = 0;
    ref_misses = 0;
    check("abort_memReq", 32'(memReq), 32'h0);
    check("abort_hitCnt", 32'(hitCnt), 32'h0);
    check("abort_missCnt", 32'(missCnt), 32'h0);
    do_access(1'b0, 32'h100, 32'h0, 0, 1'b0);          // cache was cleared

    // Random traffic.
    for (int t = 0; t < 400; t++) begin
      logic [31:0] a;
      a = ({30'h0, 2'($urandom_range(0, 3))} << 6) | ({28'h0, 4'($urandom_range(0, 15))} << 2)
          | {30'h0, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 7) == 0) a = a | 32'h8000_0000;
      do_access($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 3),
                $urandom_range(0, 15) == 0);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2), $urandom_range(0, 7) == 0);
    end
    idle(2, 1'b0);
    check("queue_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
